bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised two-digit BCD modulo counter for the stopwatch/clock time chain. One instance per time field (seconds, minutes, hours, centiseconds), all on the single system clock. Stages advance on a one-cycle tick enable instead of a derived clock, and each stage produces a one-cycle carry pulse that drives the next stage's tick. Adds synchronous preset and, optionally, down-counting for timer mode.

## Interface
Parameters:
- `MOD`, default 60: modulus; legal range 2..100; count runs 0..MOD-1.
- `RESET_VAL`, default 0: value after reset, binary; must be < MOD.

Ports:
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `tick`, input, 1: count enable; one count step per cycle in which it is high.
- `load`, input, 1: synchronous preset strobe.
- `load_low`, input, 4: BCD ones digit to preset.
- `load_high`, input, 4: BCD tens digit to preset.
- `dir_down`, input, 1: count direction, 1 = down. Present only with `BCD_DOWN_EN`.
- `digit_low`, output, 4: ones digit, registered.
- `digit_high`, output, 4: tens digit, registered.
- `carry`, output, 1: wrap pulse, registered, one cycle wide.
- `load_err`, output, 1: rejected-preset pulse, registered, one cycle wide.

## Operation
- Value V = 10·`digit_high` + `digit_low`. It is always a legal BCD value and always < MOD.
- Priority each edge: `rst` > `load` > `tick` > hold.
- Reset: digits take the BCD form of RESET_VAL; `carry` = 0; `load_err` = 0.
- Load:
  - Accepted when `load_low` ≤ 9, `load_high` ≤ 9, and the loaded value < MOD. Digits take the load values.
  - Otherwise the digits hold and `load_err` = 1 for one cycle.
  - `carry` = 0 in any load cycle.
  - A `tick` in the same cycle is dropped.
- Up count (`tick`=1, not down):
  - If V = MOD-1: V becomes 0 and `carry` = 1.
  - Else if `digit_low` = 9: `digit_low` becomes 0 and `digit_high` increments.
  - Else `digit_low` increments.
- Down count (`tick`=1, `dir_down`=1, macro enabled):
  - If V = 0: V becomes MOD-1 and `carry` = 1 (borrow).
  - Else if `digit_low` = 0: `digit_low` becomes 9 and `digit_high` decrements.
  - Else `digit_low` decrements.
- `carry` and `load_err` are 0 in every cycle that does not set them.
- Arithmetic is digit-wise BCD; there is no binary intermediate wider than 4 bits per digit. MOD-1 is split into tens/ones constants at elaboration.
- Example wrap points: MOD=24 wraps after 23; MOD=100 wraps after 99; MOD=2 toggles 00/01.

## Timing
- Latency: 1 cycle. Digits and `carry` update on the same edge that samples `tick`.
- `carry` is high for exactly the cycle after the wrap edge. This is directly usable as the next stage's `tick`, so each chained stage adds one cycle of ripple.
- `tick` held high continuously gives one step per cycle, with no minimum spacing.
- `rst` asserted mid-count overrides `load`/`tick` that cycle. A pending `carry` is cleared on that edge.
- Changing `dir_down` takes effect on the next `tick`; there is no extra state.

## Configuration
- `BCD_DOWN_EN`:
  - Defined: the `dir_down` port exists and down-count/borrow logic is built.
  - Undefined: the port is absent, the counter is up-only, and no decrement logic is synthesised.

## Structure
- Shared package `stopwatch_pkg`:
  - `bcd_t` typedef (4-bit digit).
  - `BCD_MAX = 9`.
  - Standard moduli constants `MOD_SEC = 60`, `MOD_MIN = 60`, `MOD_HOUR = 24`, `MOD_CSEC = 100`.
- Sub-module `bcd_digit`: one 4-bit digit with inc/dec, 9↔0 rollover flag, and forced-value input. Instantiated twice; the top applies the MOD wrap override.
- Elaboration check: error if MOD is outside 2..100 or RESET_VAL ≥ MOD.

## Test plan
- MOD=60, reset then 60 ticks → digits step 00..59 then 00; `carry` high exactly once, the cycle after the 59→00 edge.
- MOD=24, load 2/3 then tick → 00 with `carry`=1. Load 2/4 → digits hold, `load_err`=1 for one cycle.
- Load 0xA/0 (illegal BCD) with `tick`=1 in the same cycle → digits unchanged, `load_err`=1, `carry`=0.
- Two instances chained (MOD=60 then MOD=24) with `tick` held high, starting at 59/23 → both wrap; the second stage's `carry` comes one cycle after the first stage's.
- `rst` asserted in the cycle where V=59 and `tick`=1 → next value RESET_VAL, `carry`=0.
- `BCD_DOWN_EN`, MOD=60, V=10, `dir_down`=1, 11 ticks → 09, …, 00, 59; `carry` high only after 00→59.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/clock time chain.
// Optional build macro: BCD_DOWN_EN (enables down-counting in bcd_mod_counter).
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;
  localparam int MOD_CSEC = 100;

  // Elaboration-time split of a binary constant into its BCD tens digit.
  function automatic bcd_t const_tens(input int value);
    return bcd_t'((value / 10) % 10);
  endfunction

  // Elaboration-time split of a binary constant into its BCD ones digit.
  function automatic bcd_t const_ones(input int value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with step (inc, or dec when BCD_DOWN_EN is
// defined), natural 9<->0 rollover and a forced-value override used by the
// parent for presets and modulus wrap.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  bcd_t reset_val,
  input  logic step,
`ifdef BCD_DOWN_EN
  input  logic down,
`endif
  input  logic force_en,
  input  bcd_t force_val,
  output bcd_t q,
  output logic roll
);

  bcd_t q_stepped;

  // Next value for a single step and the flag saying this step rolls over.
  always_comb begin
    q_stepped = q;
    roll      = 1'b0;
`ifdef BCD_DOWN_EN
    if (down) begin
      roll      = (q == 4'd0);
      q_stepped = roll ? BCD_MAX : q - 4'd1;
    end else begin
      roll      = (q == BCD_MAX);
      q_stepped = roll ? 4'd0 : q + 4'd1;
    end
`else
    roll      = (q == BCD_MAX);
    q_stepped = roll ? 4'd0 : q + 4'd1;
`endif
  end

  // Digit register: reset, then forced value, then step, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= reset_val;
    end else if (force_en) begin
      q <= force_val;
    end else if (step) begin
      q <= q_stepped;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter for one field of the time chain.
// Optional build macro: BCD_DOWN_EN adds the dir_down port and borrow logic.
//
// Chaining: tick is a one-cycle enable, not a handshake; every cycle it is
// high is one step. carry is a one-cycle pulse in the cycle after the wrap
// edge and can drive the next stage's tick directly (one cycle of ripple per
// stage). There is no back-pressure: a stage never stalls its upstream.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD       = 60,
  parameter int RESET_VAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic load,
  input  bcd_t load_low,
  input  bcd_t load_high,
`ifdef BCD_DOWN_EN
  input  logic dir_down,
`endif
  output bcd_t digit_low,
  output bcd_t digit_high,
  output logic carry,
  output logic load_err
);

  // Parameter sanity check at elaboration.
  if (MOD < 2 || MOD > 100) begin : g_bad_mod
    $error("bcd_mod_counter: MOD must be in 2..100");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_reset
    $error("bcd_mod_counter: RESET_VAL must be in 0..MOD-1");
  end

  localparam bcd_t MAX_HIGH   = const_tens(MOD - 1);
  localparam bcd_t MAX_LOW    = const_ones(MOD - 1);
  localparam bcd_t RESET_HIGH = const_tens(RESET_VAL);
  localparam bcd_t RESET_LOW  = const_ones(RESET_VAL);

  logic low_step;
  logic high_step;
  logic force_en;
  bcd_t force_low;
  bcd_t force_high;
  logic carry_d;
  logic load_err_d;
  logic low_roll;
  logic unused_high_roll;
  logic at_max;
  logic load_ok;

  // Digit-wise comparisons against the split MOD-1 constant.
  assign at_max  = (digit_high == MAX_HIGH) && (digit_low == MAX_LOW);
  assign load_ok = (load_low <= BCD_MAX) && (load_high <= BCD_MAX) &&
                   ((load_high < MAX_HIGH) ||
                    ((load_high == MAX_HIGH) && (load_low <= MAX_LOW)));

`ifdef BCD_DOWN_EN
  logic at_zero;
  assign at_zero = (digit_high == 4'd0) && (digit_low == 4'd0);
`endif

  // Step/force decode: load beats tick, modulus wrap overrides the digits.
  always_comb begin
    low_step   = 1'b0;
    high_step  = 1'b0;
    force_en   = 1'b0;
    force_low  = 4'd0;
    force_high = 4'd0;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        force_en   = 1'b1;
        force_low  = load_low;
        force_high = load_high;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
`ifdef BCD_DOWN_EN
      if (dir_down) begin
        if (at_zero) begin
          force_en   = 1'b1;
          force_low  = MAX_LOW;
          force_high = MAX_HIGH;
          carry_d    = 1'b1;
        end else begin
          low_step  = 1'b1;
          high_step = low_roll;
        end
      end else
`endif
      begin
        if (at_max) begin
          force_en = 1'b1;
          carry_d  = 1'b1;
        end else begin
          low_step  = 1'b1;
          high_step = low_roll;
        end
      end
    end
  end

  bcd_digit u_low (
    .clk       (clk),
    .rst       (rst),
    .reset_val (RESET_LOW),
    .step      (low_step),
`ifdef BCD_DOWN_EN
    .down      (dir_down),
`endif
    .force_en  (force_en),
    .force_val (force_low),
    .q         (digit_low),
    .roll      (low_roll)
  );

  bcd_digit u_high (
    .clk       (clk),
    .rst       (rst),
    .reset_val (RESET_HIGH),
    .step      (high_step),
`ifdef BCD_DOWN_EN
    .down      (dir_down),
`endif
    .force_en  (force_en),
    .force_val (force_high),
    .q         (digit_high),
    .roll      (unused_high_roll)
  );

  // Registered one-cycle pulses; reset clears any pending carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= carry_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: a MOD=60 stage feeding a MOD=24 stage
// through carry->tick, plus a stand-alone MOD=24 stage with RESET_VAL=12.
// Observations are packed as {load_err, carry, digit_high, digit_low}.
module tb_bcd_mod_counter;
  import stopwatch_pkg::*;

  logic clk;
  logic rst;

  logic tick60, load60;
  bcd_t ll60, lh60;
  bcd_t d60_l, d60_h;
  logic c60, e60;

  logic tick24, load24;
  bcd_t ll24, lh24;
  bcd_t d24_l, d24_h;
  logic c24, e24;

  logic loadc;
  bcd_t llc, lhc;
  bcd_t dc_l, dc_h;
  logic cc, ec;

`ifdef BCD_DOWN_EN
  logic dir60;
`endif

  logic [9:0] exp_q[$];
  int vectors;
  int miscompares;

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_mod_counter #(.MOD(MOD_SEC), .RESET_VAL(0)) u_sec (
    .clk (clk), .rst (rst), .tick (tick60), .load (load60),
    .load_low (ll60), .load_high (lh60),
`ifdef BCD_DOWN_EN
    .dir_down (dir60),
`endif
    .digit_low (d60_l), .digit_high (d60_h), .carry (c60), .load_err (e60)
  );

  bcd_mod_counter #(.MOD(MOD_HOUR), .RESET_VAL(0)) u_chain (
    .clk (clk), .rst (rst), .tick (c60), .load (loadc),
    .load_low (llc), .load_high (lhc),
`ifdef BCD_DOWN_EN
    .dir_down (1'b0),
`endif
    .digit_low (dc_l), .digit_high (dc_h), .carry (cc), .load_err (ec)
  );

  bcd_mod_counter #(.MOD(MOD_HOUR), .RESET_VAL(12)) u_hr (
    .clk (clk), .rst (rst), .tick (tick24), .load (load24),
    .load_low (ll24), .load_high (lh24),
`ifdef BCD_DOWN_EN
    .dir_down (1'b0),
`endif
    .digit_low (d24_l), .digit_high (d24_h), .carry (c24), .load_err (e24)
  );

  function automatic logic [9:0] snap60();
    return {e60, c60, d60_h, d60_l};
  endfunction

  function automatic logic [9:0] snap24();
    return {e24, c24, d24_h, d24_l};
  endfunction

  function automatic logic [9:0] snapc();
    return {ec, cc, dc_h, dc_l};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive60(input logic t, input logic ld, input bcd_t h, input bcd_t l);
    tick60 = t; load60 = ld; lh60 = h; ll60 = l;
  endtask

  task automatic drive24(input logic t, input logic ld, input bcd_t h, input bcd_t l);
    tick24 = t; load24 = ld; lh24 = h; ll24 = l;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int v;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    drive60(1'b0, 1'b0, 4'd0, 4'd0);
    drive24(1'b0, 1'b0, 4'd0, 4'd0);
    loadc = 1'b0; llc = 4'd0; lhc = 4'd0;
`ifdef BCD_DOWN_EN
    dir60 = 1'b0;
`endif
    step();
    step();
    check("reset_sec",   snap60(), 10'h000);
    check("reset_chain", snapc(),  10'h000);
    check("reset_hr",    snap24(), 10'h012);
    rst = 1'b0;

    // 60 consecutive ticks: 01..59 then 00 with carry
    v = 0;
    for (int i = 0; i < 60; i++) begin
      v = (v + 1) % 60;
      exp_q.push_back({1'b0, (v == 0), 4'((v / 10) % 10), 4'(v % 10)});
    end
    drive60(1'b1, 1'b0, 4'd0, 4'd0);
    while (exp_q.size() > 0) begin
      step();
      check("up60_seq", snap60(), exp_q.pop_front());
    end
    drive60(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("up60_hold", snap60(), 10'h000);
    check("chain_step", snapc(), 10'h001);

    // Hours stage: preset, wrap and rejected loads
    drive24(1'b0, 1'b1, 4'd2, 4'd3);
    step();
    check("load_23", snap24(), 10'h023);
    drive24(1'b1, 1'b0, 4'd0, 4'd0);
    step();
    check("wrap_23", snap24(), 10'h100);
    drive24(1'b0, 1'b1, 4'd2, 4'd4);
    step();
    check("load_24_rej", snap24(), 10'h200);
    drive24(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("err_clear", snap24(), 10'h000);
    drive24(1'b0, 1'b1, 4'd1, 4'd9);
    step();
    check("load_19", snap24(), 10'h019);
    drive24(1'b0, 1'b1, 4'd3, 4'd0);
    step();
    check("load_30_rej", snap24(), 10'h219);
    drive24(1'b0, 1'b1, 4'd1, 4'd5);
    step();
    check("load_15", snap24(), 10'h015);
    drive24(1'b1, 1'b1, 4'd0, 4'hA);
    step();
    check("load_0a_tick", snap24(), 10'h215);
    drive24(1'b0, 1'b1, 4'hA, 4'd0);
    step();
    check("load_a0_rej", snap24(), 10'h215);
    drive24(1'b1, 1'b0, 4'd0, 4'd0);
    step();
    check("tick_16", snap24(), 10'h016);
    drive24(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("hold_16", snap24(), 10'h016);

    // Chained wrap from 59 / 23
    drive60(1'b0, 1'b1, 4'd5, 4'd9);
    loadc = 1'b1; lhc = 4'd2; llc = 4'd3;
    step();
    check("chain_ld_sec", snap60(), 10'h059);
    check("chain_ld_hr",  snapc(),  10'h023);
    loadc = 1'b0;
    drive60(1'b1, 1'b0, 4'd0, 4'd0);
    step();
    check("chain_w1_sec", snap60(), 10'h100);
    check("chain_w1_hr",  snapc(),  10'h023);
    step();
    check("chain_w2_sec", snap60(), 10'h001);
    check("chain_w2_hr",  snapc(),  10'h100);
    drive60(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("chain_w3_hr",  snapc(),  10'h000);

    // Reset at V=59 with tick
    drive60(1'b0, 1'b1, 4'd5, 4'd9);
    step();
    check("pre_rst_59", snap60(), 10'h059);
    drive60(1'b1, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    step();
    check("rst_sec", snap60(), 10'h000);
    check("rst_hr",  snap24(), 10'h012);
    rst = 1'b0;
    drive60(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("post_rst_hold", snap60(), 10'h000);

`ifdef BCD_DOWN_EN
    // Down-count from 10 through the borrow at 00
    dir60 = 1'b1;
    drive60(1'b0, 1'b1, 4'd1, 4'd0);
    step();
    check("down_load_10", snap60(), 10'h010);
    for (int i = 9; i >= 0; i--) exp_q.push_back({2'b00, 4'd0, 4'(i)});
    exp_q.push_back(10'h159);
    drive60(1'b1, 1'b0, 4'd0, 4'd0);
    while (exp_q.size() > 0) begin
      step();
      check("down_seq", snap60(), exp_q.pop_front());
    end
    drive60(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("down_hold", snap60(), 10'h059);
    dir60 = 1'b0;
`endif

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
